// File: rtl/irq_controller_if.sv
// Bus bundle between the interrupt controller and the core-side logic.
// master: the side that drives requests, mie, stall and mret.
// slave:  the interrupt controller itself.
interface irq_controller_if #(
    parameter int N_IRQ = 16
);
    logic [N_IRQ-1:0] irq_req_i;
    logic [31:0]      mie_i;
    logic             stall_i;
    logic             mret_i;
    logic             irq_o;
    logic [31:0]      mcause_o;
    logic [N_IRQ-1:0] irq_ret_o;
    logic             busy_o;

    modport master (
        output irq_req_i, mie_i, stall_i, mret_i,
        input  irq_o, mcause_o, irq_ret_o, busy_o
    );

    modport slave (
        input  irq_req_i, mie_i, stall_i, mret_i,
        output irq_o, mcause_o, irq_ret_o, busy_o
    );
endinterface

// File: rtl/irq_controller.sv
// Interrupt sequencer: masks peripheral requests with mie, picks the lowest
// pending index, raises a trap with its mcause, holds it in service until
// mret and then returns a one-hot acknowledge to the serviced line.
// Optional build macro IRQ_EDGE_DETECT_EN switches from level-sensitive
// requests to rising-edge capture with a sticky edge-pending register.
//
// state   | meaning
// IDLE    | waiting for an enabled pending request
// TRAP    | irq_o raised, waiting for the core to accept (stall_i low)
// SERVICE | handler running, waiting for mret_i
// RETURN  | one-cycle acknowledge on irq_ret_o
module irq_controller #(
    parameter int          N_IRQ       = 16,
    parameter logic [31:0] MCAUSE_BASE = 32'h8000_0010
) (
    input  logic            clk_i,
    input  logic            rst_i,
    irq_controller_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRAP,
        ST_SERVICE,
        ST_RETURN
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       id_q, id_d;
    logic [31:0]      mcause_q, mcause_d;
    logic             irq_q, irq_d;
    logic             busy_q, busy_d;
    logic [N_IRQ-1:0] ret_q, ret_d;
    logic [N_IRQ-1:0] pending;
    logic [3:0]       win_idx;
    logic             win_vld;

    // mie bits above the implemented lines carry no meaning here
    logic unused_mie;
    assign unused_mie = &{1'b0, bus.mie_i[31:N_IRQ]};

`ifdef IRQ_EDGE_DETECT_EN
    logic [N_IRQ-1:0] req_q;
    logic [N_IRQ-1:0] edge_pend_q;
    logic [N_IRQ-1:0] edge_clr;

    // Clear mask for the line being acknowledged this cycle
    always_comb begin
        edge_clr = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            edge_clr[i] = (state_q == ST_RETURN) && (id_q == 4'(i));
        end
    end

    // Edge capture: a fresh rising edge overrides a same-cycle clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_q       <= '0;
            edge_pend_q <= '0;
        end else begin
            req_q       <= bus.irq_req_i;
            edge_pend_q <= (edge_pend_q & ~edge_clr) | (bus.irq_req_i & ~req_q);
        end
    end

    assign pending = edge_pend_q & bus.mie_i[N_IRQ-1:0];
`else
    assign pending = bus.irq_req_i & bus.mie_i[N_IRQ-1:0];
`endif

    // Fixed priority: scan downwards so the lowest set index is left last
    always_comb begin
        win_idx = '0;
        win_vld = |pending;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) win_idx = 4'(i);
        end
    end

    // Next state plus next values of the registered outputs
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        mcause_d = mcause_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld && !bus.stall_i) begin
                    state_d  = ST_TRAP;
                    id_d     = win_idx;
                    mcause_d = MCAUSE_BASE + {28'd0, win_idx};
                end
            end
            ST_TRAP:    if (!bus.stall_i) state_d = ST_SERVICE;
            ST_SERVICE: if (bus.mret_i)   state_d = ST_RETURN;
            ST_RETURN:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        irq_d  = (state_d == ST_TRAP);
        busy_d = (state_d == ST_TRAP) || (state_d == ST_SERVICE);
        ret_d  = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            ret_d[i] = (state_d == ST_RETURN) && (id_d == 4'(i));
        end
    end

    // State and output registers; reset aborts any interrupt in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            id_q     <= '0;
            mcause_q <= '0;
            irq_q    <= 1'b0;
            busy_q   <= 1'b0;
            ret_q    <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            mcause_q <= mcause_d;
            irq_q    <= irq_d;
            busy_q   <= busy_d;
            ret_q    <= ret_d;
        end
    end

    assign bus.irq_o     = irq_q;
    assign bus.busy_o    = busy_q;
    assign bus.mcause_o  = mcause_q;
    assign bus.irq_ret_o = ret_q;
endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: a vector table applied cycle by cycle, with the
// expected registered outputs queued on drive and compared after the edge,
// plus hand-written stall, back-to-back and reset-abort sequences.
module tb_irq_controller;
    localparam int          N_IRQ = 16;
    localparam logic [31:0] MB    = 32'h8000_0010;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    irq_controller_if #(.N_IRQ(N_IRQ)) bus ();

    irq_controller #(
        .N_IRQ       (N_IRQ),
        .MCAUSE_BASE (MB)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] req;
        logic [31:0] mie;
        logic        stall;
        logic        mret;
        logic        irq;
        logic [31:0] mcause;
        logic [15:0] ret;
        logic        busy;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_passed = 0;

    function automatic vec_t mk(input logic [15:0] req, input logic [31:0] mie,
                                input logic stall, input logic mret,
                                input logic irq, input logic [31:0] mcause,
                                input logic [15:0] ret, input logic busy);
        vec_t v;
        v.req = req; v.mie = mie; v.stall = stall; v.mret = mret;
        v.irq = irq; v.mcause = mcause; v.ret = ret; v.busy = busy;
        return v;
    endfunction

    task automatic check_outs(input string nm, input logic irq, input logic [31:0] mcause,
                              input logic [15:0] ret, input logic busy);
        n_checks++;
        if ({bus.irq_o, bus.mcause_o, bus.irq_ret_o, bus.busy_o} !== {irq, mcause, ret, busy}) begin
            $display("FAIL %s: got irq=%b mcause=%h ret=%h busy=%b, want irq=%b mcause=%h ret=%h busy=%b",
                     nm, bus.irq_o, bus.mcause_o, bus.irq_ret_o, bus.busy_o, irq, mcause, ret, busy);
        end else begin
            n_passed++;
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, compare after the edge
    task automatic apply(input vec_t v, input string nm);
        vec_t e;
        bus.irq_req_i = v.req;
        bus.mie_i     = v.mie;
        bus.stall_i   = v.stall;
        bus.mret_i    = v.mret;
        exp_q.push_back(v);
        @(posedge clk_i);
        #1;
        e = exp_q.pop_front();
        check_outs(nm, e.irq, e.mcause, e.ret, e.busy);
    endtask

    task automatic run_table(input string nm);
        foreach (tbl[i]) apply(tbl[i], $sformatf("%s[%0d]", nm, i));
        tbl.delete();
    endtask

    initial begin
        bus.irq_req_i = '0;
        bus.mie_i     = '0;
        bus.stall_i   = 1'b0;
        bus.mret_i    = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check_outs("reset", 1'b0, 32'h0, 16'h0, 1'b0);
        rst_i = 1'b0;

`ifdef IRQ_EDGE_DETECT_EN
        // Line 2 held high: one trap only; drop and re-raise gives a second
        tbl.push_back(mk(16'h4, 32'h4, 0, 0, 0, 32'h0,   16'h0, 0));
        tbl.push_back(mk(16'h4, 32'h4, 0, 0, 1, MB + 2,  16'h0, 1));
        tbl.push_back(mk(16'h4, 32'h4, 0, 0, 0, MB + 2,  16'h0, 1));
        tbl.push_back(mk(16'h4, 32'h4, 0, 1, 0, MB + 2,  16'h4, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(16'h4, 32'h4, 0, 0, 0, MB + 2, 16'h0, 0));
        tbl.push_back(mk(16'h0, 32'h4, 0, 0, 0, MB + 2,  16'h0, 0));
        tbl.push_back(mk(16'h4, 32'h4, 0, 0, 0, MB + 2,  16'h0, 0));
        tbl.push_back(mk(16'h4, 32'h4, 0, 0, 1, MB + 2,  16'h0, 1));
        tbl.push_back(mk(16'h4, 32'h4, 0, 0, 0, MB + 2,  16'h0, 1));
        tbl.push_back(mk(16'h4, 32'h4, 0, 1, 0, MB + 2,  16'h4, 0));
        tbl.push_back(mk(16'h4, 32'h4, 0, 0, 0, MB + 2,  16'h0, 0));
        run_table("edge");
`else
        // Single request on line 2, mret in the sixth cycle
        tbl.push_back(mk(16'h4, 32'h4, 0, 0, 1, MB + 2, 16'h0, 1));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(16'h4, 32'h4, 0, 0, 0, MB + 2, 16'h0, 1));
        tbl.push_back(mk(16'h0, 32'h4, 0, 1, 0, MB + 2, 16'h4, 0));
        tbl.push_back(mk(16'h0, 32'h4, 0, 0, 0, MB + 2, 16'h0, 0));
        // Lines 4 and 5 together: 4 first, then 5
        tbl.push_back(mk(16'h30, 32'hFFFF, 0, 0, 1, MB + 4, 16'h0,  1));
        tbl.push_back(mk(16'h30, 32'hFFFF, 0, 0, 0, MB + 4, 16'h0,  1));
        tbl.push_back(mk(16'h20, 32'hFFFF, 0, 1, 0, MB + 4, 16'h10, 0));
        tbl.push_back(mk(16'h20, 32'hFFFF, 0, 0, 0, MB + 4, 16'h0,  0));
        tbl.push_back(mk(16'h20, 32'hFFFF, 0, 0, 1, MB + 5, 16'h0,  1));
        tbl.push_back(mk(16'h20, 32'hFFFF, 0, 0, 0, MB + 5, 16'h0,  1));
        tbl.push_back(mk(16'h0,  32'hFFFF, 0, 1, 0, MB + 5, 16'h20, 0));
        tbl.push_back(mk(16'h0,  32'hFFFF, 0, 0, 0, MB + 5, 16'h0,  0));
        // Masked line 0 for 10 cycles, then enabled; mie drop in SERVICE is ignored
        for (int i = 0; i < 10; i++) tbl.push_back(mk(16'h1, 32'h0, 0, 0, 0, MB + 5, 16'h0, 0));
        tbl.push_back(mk(16'h1, 32'h1, 0, 0, 1, MB, 16'h0, 1));
        tbl.push_back(mk(16'h1, 32'h0, 0, 0, 0, MB, 16'h0, 1));
        tbl.push_back(mk(16'h0, 32'h0, 0, 1, 0, MB, 16'h1, 0));
        tbl.push_back(mk(16'h0, 32'h0, 0, 1, 0, MB, 16'h0, 0));
        tbl.push_back(mk(16'h0, 32'h0, 0, 1, 0, MB, 16'h0, 0));
        run_table("main");

        // Stall blocks IDLE->TRAP, then holds irq_o high inside TRAP;
        // mret and input changes during TRAP must not disturb the latch
        for (int i = 0; i < 3; i++) apply(mk(16'h8, 32'h8, 1, 0, 0, MB, 16'h0, 0), "stall_idle");
        apply(mk(16'h8, 32'h8, 0, 0, 1, MB + 3, 16'h0, 1), "stall_release");
        apply(mk(16'h1, 32'h1, 1, 1, 1, MB + 3, 16'h0, 1), "stall_trap_mret");
        apply(mk(16'h8, 32'h8, 1, 0, 1, MB + 3, 16'h0, 1), "stall_trap_hold");
        apply(mk(16'h8, 32'h8, 0, 0, 0, MB + 3, 16'h0, 1), "stall_accept");
        apply(mk(16'h0, 32'h8, 0, 1, 0, MB + 3, 16'h8, 0), "stall_ret");
        apply(mk(16'h0, 32'h8, 0, 0, 0, MB + 3, 16'h0, 0), "stall_idle_after");

        // Held level on line 1: mret at t, ack t+1, idle t+2, next irq t+3
        apply(mk(16'h2, 32'h2, 0, 0, 1, MB + 1, 16'h0, 1), "b2b_trap1");
        apply(mk(16'h2, 32'h2, 0, 0, 0, MB + 1, 16'h0, 1), "b2b_svc1");
        apply(mk(16'h2, 32'h2, 0, 1, 0, MB + 1, 16'h2, 0), "b2b_ret1");
        apply(mk(16'h2, 32'h2, 0, 0, 0, MB + 1, 16'h0, 0), "b2b_idle");
        apply(mk(16'h2, 32'h2, 0, 0, 1, MB + 1, 16'h0, 1), "b2b_trap2");
        apply(mk(16'h2, 32'h2, 0, 0, 0, MB + 1, 16'h0, 1), "b2b_svc2");

        // Asynchronous reset in SERVICE: outputs clear before any edge
        rst_i = 1'b1;
        #2;
        check_outs("async_reset", 1'b0, 32'h0, 16'h0, 1'b0);
        bus.irq_req_i = '0;
        bus.mret_i    = 1'b1;
        @(posedge clk_i);
        #1;
        check_outs("reset_held", 1'b0, 32'h0, 16'h0, 1'b0);
        rst_i = 1'b0;
        apply(mk(16'h0, 32'h2, 0, 1, 0, 32'h0, 16'h0, 0), "spurious_mret");
        for (int i = 0; i < 3; i++) apply(mk(16'h0, 32'h2, 0, 0, 0, 32'h0, 16'h0, 0), "no_ack_after_reset");
`endif

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt sequencer sitting between peripheral IRQ lines and the core's CSR/trap path.
- Masks requests with the CSR-supplied mie value and picks the highest-priority pending line (lowest index).
- Raises a trap with the matching mcause, holds the interrupt as "in service" until mret, then returns a one-hot acknowledge to the serviced peripheral.
- Feeds the CSR controller's trap and mcause inputs; consumes its mie output.

Parameters:
- N_IRQ, 16, number of interrupt request lines (legal range 1..16).
- MCAUSE_BASE, 32'h8000_0010, mcause value reported for line 0; line k reports MCAUSE_BASE + k.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- irq_req_i  input  N_IRQ  peripheral interrupt requests, level, active-high.
- mie_i  input  32  mie CSR value; bit k enables line k (bits above N_IRQ-1 ignored).
- stall_i  input  1  core cannot accept a trap this cycle.
- mret_i  input  1  one-cycle pulse, core executed mret.
- irq_o  output  1  trap request to core/CSR controller.
- mcause_o  output  32  cause of the current interrupt.
- irq_ret_o  output  N_IRQ  one-hot acknowledge to the serviced line, one cycle.
- busy_o  output  1  an interrupt is in flight (TRAP or SERVICE).

Behaviour:
- Interface: one clock `clk_i`; reset `rst_i` is asynchronous and active-high.
- Reset values: state = IDLE, irq_o = 0, mcause_o = 0, irq_ret_o = 0, busy_o = 0, latched id = 0, edge-pending register = 0.
- pending = irq_req_i & mie_i[N_IRQ-1:0]. Under IRQ_EDGE_DETECT_EN, the edge-pending register is used instead (see Optional Feature).
- Priority: lowest set index wins. Index is 4 bits; mcause = MCAUSE_BASE + zero-extended index, 32-bit, no overflow check.
- All outputs are registered. FSM states:
  - IDLE: if |pending && !stall_i, latch the winning index, load mcause_o, go to TRAP. Otherwise stay. stall_i blocks only the IDLE→TRAP decision.
  - TRAP: irq_o = 1 and busy_o = 1. Stay while stall_i = 1 (irq_o held high). When stall_i = 0, go to SERVICE, so irq_o is high for exactly one unstalled cycle.
  - SERVICE: irq_o = 0, busy_o = 1, mcause_o held. On mret_i, go to RETURN.
  - RETURN: irq_ret_o = 1 << latched index for one cycle, busy_o = 0, then go to IDLE. mcause_o keeps its value until the next trap.
- Latency: pending asserted in cycle t with stall_i = 0 → irq_o high in cycle t+1.
- Back-to-back interrupts: mret_i in cycle t → irq_ret_o in t+1 → IDLE in t+2. The earliest next irq_o is t+3.
- mret_i outside SERVICE is ignored.
- Changes to mie_i or irq_req_i after the latch (in TRAP or SERVICE) do not alter the latched index or mcause.
- Simultaneous requests: only the winner is serviced. Others stay pending (level) and are taken in a later IDLE.
- Reset asserted mid-operation: immediate return to reset values. No irq_ret_o is generated for the aborted interrupt.
- All bits of mie_i[N_IRQ-1:0] zero: never leaves IDLE.

Optional Feature:
- Macro: IRQ_EDGE_DETECT_EN.
- Defined:
  - A per-line registered copy of irq_req_i detects rising edges.
  - A rising edge sets the line's bit in the edge-pending register. The bit is set regardless of mie; the mie mask is applied at arbitration.
  - In RETURN, the serviced line's bit is cleared. A new edge arriving on that same line in that same cycle wins, and the bit stays set.
  - Arbitration uses edge-pending & mie_i.
- Not defined: level mode as above, no edge registers. A line held high re-triggers after RETURN.

Test Plan:
- Single IRQ: mie_i = 32'h4, irq_req_i = 16'h0004 in cycle 0 → irq_o = 1 in cycle 1 only, mcause_o = 32'h8000_0012. mret_i in cycle 5 → irq_ret_o = 16'h0004 in cycle 6, busy_o = 0 in cycle 6.
- Priority: irq_req_i = 16'h0030, mie_i = 32'hFFFF → mcause_o = 32'h8000_0014. After mret, line 5 is serviced next with mcause_o = 32'h8000_0015 and irq_ret_o = 16'h0020.
- Masking: irq_req_i = 16'h0001, mie_i = 0 for 10 cycles → irq_o and busy_o stay 0. Set mie_i = 1 → irq_o on the next cycle.
- Stall: pending line 3 with stall_i = 1 for 3 cycles → no irq_o. stall_i drops → irq_o one cycle later. Then stall_i = 1 during TRAP → irq_o held high until stall_i = 0.
- Reset mid-service: async rst_i pulse in SERVICE → all outputs 0 immediately, no irq_ret_o. A spurious mret_i in IDLE → no effect.
- Edge mode (IRQ_EDGE_DETECT_EN): line 2 held high continuously → exactly one trap. Drop and re-raise → a second trap.
